mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timeout.sv | 44 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared definitions for the instruction/data memory arbiter.
//
// Contents:
//   DATA_W          : width of addresses and data words on every port
//   TIMEOUT_DEFAULT : default number of busy cycles allowed before an access
//                     is abandoned
//   arb_state_t     : arbiter FSM state encoding
//
// Optional feature (selected in mem_arbiter): MEM_ARB_RR_EN
package mem_arb_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    DM_BUSY,
    IF_BUSY,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout -- busy-cycle watchdog for the memory arbiter.
//
// Counts the cycles the arbiter spends waiting on the shared memory port and
// flags the cycle in which the allowance is used up.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   busy    : arbiter is waiting on the memory port this cycle
//   expired : this busy cycle is the last one allowed (TIMEOUT-th busy cycle)
//
// TIMEOUT must be at least 1.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // The counter sits at zero whenever the arbiter is not busy, so it is
  // effectively cleared on every entry into a busy state. It holds at LAST
  // because the arbiter always leaves the busy state in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!busy) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = busy && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between the fetch stage (IF) and the
// memory stage (DM) of a pipelined core.
//
// Ports:
//   clk_i, rst_i              : clock and synchronous active-high reset
//   if_req_i, if_addr_i       : fetch read request (held until if_ack_o)
//   if_ack_o, if_rdata_o      : one-cycle fetch completion pulse, fetch data
//   dm_rd_i, dm_wr_i          : data read / write request (held until dm_ack_o);
//                               both high is treated as a write
//   dm_addr_i, dm_wdata_i     : data address / write data
//   dm_ack_o, dm_rdata_o      : one-cycle data completion pulse, load data
//   mem_req_o, mem_we_o       : shared port request / write enable
//   mem_addr_o, mem_wdata_o   : shared port address / write data
//   mem_ack_i, mem_rdata_i    : shared port completion / read data
//   stall_o                   : freeze the pipeline while a request is pending
//   timeout_o                 : sticky flag, an access was abandoned
//
// Build option:
//   MEM_ARB_RR_EN defined   : round-robin between IF and DM on collisions
//   MEM_ARB_RR_EN undefined : DM always wins a collision
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_rd_i,
  input  logic              dm_wr_i,
  input  logic [DATA_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              timeout_o
);

  arb_state_t state;
  logic       dm_req;
  logic       busy;
  logic       expired;
  logic       grant_dm;

  assign dm_req = dm_rd_i | dm_wr_i;
  assign busy   = (state == DM_BUSY) || (state == IF_BUSY);

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk_i),
    .rst     (rst_i),
    .busy    (busy),
    .expired (expired)
  );

`ifdef MEM_ARB_RR_EN
  logic last_dm;

  // On a collision, IF gets its turn only when DM had the previous grant.
  assign grant_dm = dm_req & (~if_req_i | ~last_dm);

  // Remember who received the most recent grant; cleared so DM goes first
  // after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_dm <= 1'b0;
    end else if ((state == IDLE) && (dm_req || if_req_i)) begin
      last_dm <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  // Arbiter FSM. All memory-port and completion outputs are registered here;
  // the memory-port signals carry the latched access only while busy, and
  // the ack registers default low so each completion is a single pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state       <= DM_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_wr_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
          end else if (if_req_i) begin
            state       <= IF_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
          end
        end
        DM_BUSY, IF_BUSY: begin
          // A real ack wins over an expiring watchdog in the same cycle;
          // an abandoned access completes with zero data.
          if (mem_ack_i || expired) begin
            state       <= DONE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if (!mem_ack_i) begin
              timeout_o <= 1'b1;
            end
            if (state == DM_BUSY) begin
              dm_ack_o   <= 1'b1;
              dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the pipeline freezes in the very cycle a request appears
  // and releases in the cycle its ack is seen.
  assign stall_o = (dm_req & ~dm_ack_o) | (if_req_i & ~if_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
//
// A main instance (default TIMEOUT) is exercised with directed and random
// requests; a second instance with TIMEOUT=4 and a silent memory port covers
// the abandoned-access path. Build option MEM_ARB_RR_EN is honoured by the
// reference model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic        if_req, if_ack, dm_rd, dm_wr, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, stall, timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        t_if_req, t_if_ack, t_dm_rd, t_dm_wr, t_dm_ack;
  logic [31:0] t_if_addr, t_if_rdata, t_dm_addr, t_dm_wdata, t_dm_rdata;
  logic        t_mem_req, t_mem_we, t_mem_ack, t_stall, t_timeout;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  bit          prev_grant_dm = 1'b0;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .dm_rd_i(dm_rd), .dm_wr_i(dm_wr), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .stall_o(stall), .timeout_o(timeout)
  );

  mem_arbiter #(.TIMEOUT(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(t_if_req), .if_addr_i(t_if_addr), .if_ack_o(t_if_ack), .if_rdata_o(t_if_rdata),
    .dm_rd_i(t_dm_rd), .dm_wr_i(t_dm_wr), .dm_addr_i(t_dm_addr), .dm_wdata_i(t_dm_wdata),
    .dm_ack_o(t_dm_ack), .dm_rdata_o(t_dm_rdata),
    .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_wdata_o(t_mem_wdata),
    .mem_ack_i(t_mem_ack), .mem_rdata_i(t_mem_rdata),
    .stall_o(t_stall), .timeout_o(t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to 1 time unit after the next rising edge.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Serve one granted access. Entered in the cycle the arbiter samples the
  // grant; returns in the IDLE cycle after the completion pulse, with the
  // owner's request already dropped.
  task automatic serveOne(input bit is_dm, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] rdata, input bit spurious,
                          input bit other_pending);
    for (int k = 1; k <= delay; k++) begin
      nextCycle;
      checkOutput("busy mem_req", 32'(mem_req), 32'd1);
      checkOutput("busy mem_addr", mem_addr, addr);
      checkOutput("busy mem_we", 32'(mem_we), 32'(we));
      checkOutput("busy mem_wdata", mem_wdata, wdata);
      checkOutput("busy acks", {30'd0, if_ack, dm_ack}, 32'd0);
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      #1;
      checkOutput("busy stall", 32'(stall), 32'd1);
    end
    nextCycle;
    if (is_dm) exp_dm_rdata = rdata;
    else       exp_if_rdata = rdata;
    checkOutput("done dm_ack", 32'(dm_ack), 32'(is_dm));
    checkOutput("done if_ack", 32'(if_ack), 32'(!is_dm));
    checkOutput("done dm_rdata", dm_rdata, exp_dm_rdata);
    checkOutput("done if_rdata", if_rdata, exp_if_rdata);
    checkOutput("done mem_req", 32'(mem_req), 32'd0);
    checkOutput("done mem_addr", mem_addr, 32'd0);
    mem_ack   = spurious;
    mem_rdata = $urandom;
    #1;
    checkOutput("done stall", 32'(stall), 32'(other_pending));
    nextCycle;
    if (is_dm) begin
      dm_rd = 1'b0;
      dm_wr = 1'b0;
    end else begin
      if_req = 1'b0;
    end
    mem_ack = 1'b0;
    checkOutput("idle acks", {30'd0, if_ack, dm_ack}, 32'd0);
    checkOutput("idle mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle dm_rdata hold", dm_rdata, exp_dm_rdata);
    checkOutput("idle if_rdata hold", if_rdata, exp_if_rdata);
    #1;
    checkOutput("idle stall", 32'(stall), 32'(other_pending));
    prev_grant_dm = is_dm;
  endtask

  // Present a set of requests in one cycle and serve them in arbitration order.
  task automatic applyStimulus(input bit req_if, input bit req_rd, input bit req_wr,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] dw, input int d_if, input int d_dm,
                               input logic [31:0] r_if, input logic [31:0] r_dm,
                               input bit spur);
    bit has_dm;
    bit dm_first;
    nextCycle;
    checkOutput("pre mem_req", 32'(mem_req), 32'd0);
    checkOutput("pre acks", {30'd0, if_ack, dm_ack}, 32'd0);
    if_req   = req_if;
    if_addr  = ia;
    dm_rd    = req_rd;
    dm_wr    = req_wr;
    dm_addr  = da;
    dm_wdata = dw;
    mem_ack  = 1'b0;
    #1;
    checkOutput("req stall", 32'(stall), 32'(req_if | req_rd | req_wr));
    has_dm   = req_rd | req_wr;
    dm_first = has_dm && (!req_if || !(RR && prev_grant_dm));
    if (dm_first) begin
      serveOne(1'b1, da, req_wr, dw, d_dm, r_dm, spur, req_if);
      if (req_if) serveOne(1'b0, ia, 1'b0, 32'd0, d_if, r_if, spur, 1'b0);
    end else if (req_if) begin
      serveOne(1'b0, ia, 1'b0, 32'd0, d_if, r_if, spur, has_dm);
      if (has_dm) serveOne(1'b1, da, req_wr, dw, d_dm, r_dm, spur, 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctl"}, {26'd0, mem_req, mem_we, if_ack, dm_ack, stall, timeout}, 32'd0);
    checkOutput({tag, " mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, " if_rdata"}, if_rdata, 32'd0);
    checkOutput({tag, " dm_rdata"}, dm_rdata, 32'd0);
  endtask

  // Abandoned-access path on the TIMEOUT=4 instance.
  task automatic timeoutTest;
    nextCycle;
    t_dm_rd = 1'b1; t_dm_addr = 32'h40;
    nextCycle;
    checkOutput("to normal mem_req", 32'(t_mem_req), 32'd1);
    nextCycle;
    t_mem_ack = 1'b1; t_mem_rdata = 32'h1234_5678;
    nextCycle;
    t_mem_ack = 1'b0;
    checkOutput("to normal ack", 32'(t_dm_ack), 32'd1);
    checkOutput("to normal rdata", t_dm_rdata, 32'h1234_5678);
    checkOutput("to normal flag", 32'(t_timeout), 32'd0);
    nextCycle;
    t_dm_rd = 1'b0;
    nextCycle;
    t_dm_rd = 1'b1; t_dm_addr = 32'h44;
    for (int k = 1; k <= 4; k++) begin
      nextCycle;
      checkOutput("to busy mem_req", 32'(t_mem_req), 32'd1);
      checkOutput("to busy flag", 32'(t_timeout), 32'd0);
      checkOutput("to busy ack", 32'(t_dm_ack), 32'd0);
    end
    nextCycle;
    checkOutput("to expire ack", 32'(t_dm_ack), 32'd1);
    checkOutput("to expire flag", 32'(t_timeout), 32'd1);
    checkOutput("to expire rdata", t_dm_rdata, 32'd0);
    checkOutput("to expire mem_req", 32'(t_mem_req), 32'd0);
    nextCycle;
    t_dm_rd = 1'b0;
    checkOutput("to after ack", 32'(t_dm_ack), 32'd0);
    checkOutput("to sticky", 32'(t_timeout), 32'd1);
    nextCycle;
    checkOutput("to idle mem_req", 32'(t_mem_req), 32'd0);
    checkOutput("to idle sticky", 32'(t_timeout), 32'd1);
  endtask

  // Reset while DM_BUSY, then a late ack that must be ignored.
  task automatic resetMidTest;
    nextCycle;
    dm_rd = 1'b1; dm_addr = 32'h80;
    nextCycle;
    checkOutput("rst busy mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    dm_rd = 1'b0;
    nextCycle;
    checkAllZero("rst applied");
    checkOutput("rst to flag", 32'(t_timeout), 32'd0);
    exp_dm_rdata  = '0;
    exp_if_rdata  = '0;
    prev_grant_dm = 1'b0;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    nextCycle;
    mem_ack = 1'b0;
    checkAllZero("rst late ack");
  endtask

  task automatic randomBatch(input int count);
    for (int i = 0; i < count; i++) begin
      int  kind;
      bit  rd, wr;
      kind = $urandom_range(0, 2);
      rd   = $urandom_range(0, 1);
      wr   = !rd || ($urandom_range(0, 3) == 0);
      applyStimulus(kind != 1, kind != 0 && rd, kind != 0 && wr,
                    $urandom, $urandom, $urandom,
                    $urandom_range(1, 6), $urandom_range(1, 6),
                    $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    t_if_req = 0; t_if_addr = '0; t_dm_rd = 0; t_dm_wr = 0; t_dm_addr = '0; t_dm_wdata = '0;
    t_mem_ack = 0; t_mem_rdata = '0;
    nextCycle;
    nextCycle;
    checkAllZero("reset");
    rst = 1'b0;

    timeoutTest;

    // Single load with minimum latency.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 1, 1,
                  32'h0, 32'hDEAD_BEEF, 1'b0);
    // Collision with a store, a lone DM access, then a second collision.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 32'h200, 32'hCAFE_0001, 2, 1,
                  32'h1111_0000, 32'h2222_0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'h0BAD_F00D, 1, 3,
                  32'h0, 32'h3333_0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h104, 32'h204, 32'h0, 1, 2,
                  32'h4444_0000, 32'h5555_0000, 1'b1);
    // Slow memory: ack in the fifth busy cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0, 1, 5,
                  32'h0, 32'h6666_0000, 1'b0);

    randomBatch(40);
    resetMidTest;
    randomBatch(10);

    checkOutput("main timeout clear", 32'(timeout), 32'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
